// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the floating-point datapath blocks.
// Holds the operand class encoding, exception flag bit positions and
// helper functions that derive the exponent bias, the all-ones exponent
// and the canonical quiet NaN from the exponent and mantissa widths.
package fp_pkg;

  // Operand class, decided once from the raw fields and then carried down the pipe
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Biased exponent value reserved for inf/NaN
  function automatic int fp_max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  // Returned wide; callers truncate to their word width.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = ((128'd1 << exp_w) - 128'd1) << man_w;
    v = v | (128'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round / pack stage.
// Inputs : sign, cls_a/cls_b (operand classes), exp_in (signed biased
//          exponent before normalisation), prod (raw 1.x * 1.x product).
// Outputs: result (packed word), flags {invalid, overflow, underflow, inexact}.
// Rounding is round-to-nearest-even; out-of-range exponents saturate to
// inf or flush to zero.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  fp_class_e                cls_a,
  input  fp_class_e                cls_b,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int XW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam logic signed [XW-1:0] MAX_EXP = XW'(fp_max_exp(EXP_W));
  localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, MAN_W));

  logic [PW-1:0]          norm;
  logic                   msb;
  logic [MAN_W:0]         mant;
  logic                   guard;
  logic                   rnd;
  logic                   sticky;
  logic                   round_up;
  logic [MAN_W+1:0]       mant_r;
  logic [MAN_W-1:0]       frac;
  logic signed [XW-1:0]   exp_f;
  logic                   nan_a, nan_b, inf_any, zero_any, zero_inf;

  always_comb begin
    // Product lies in [1,4); left-align it so the hidden bit is always the MSB
    msb      = prod[PW-1];
    norm     = msb ? prod : (prod << 1);
    mant     = norm[PW-1 -: MAN_W+1];
    guard    = norm[MAN_W];
    rnd      = norm[MAN_W-1];
    sticky   = |norm[MAN_W-2:0];
    round_up = guard & (rnd | sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_W+2)'(round_up);
    // A rounding carry means the mantissa became exactly 2.0
    frac     = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_f    = exp_in + $signed({{(XW-1){1'b0}}, msb})
                      + $signed({{(XW-1){1'b0}}, mant_r[MAN_W+1]});

    nan_a    = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN);
    nan_b    = (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    inf_any  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    zero_any = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    zero_inf = inf_any && zero_any;

    result = '0;
    flags  = '0;
    if (nan_a || nan_b || zero_inf) begin
      result = QNAN;
      flags[FLAG_INVALID] = zero_inf || (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    end else if (inf_any) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      result = {sign, {(W-1){1'b0}}};
    end else if (exp_f >= MAX_EXP) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= 0) begin
      result = {sign, {(W-1){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result = {sign, exp_f[EXP_W-1:0], frac};
      flags[FLAG_INEXACT] = guard | rnd | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand
// handshake; out_valid/out_ready/result/flags result handshake.
// Stage 1 unpacks and classifies, stage 2 multiplies the mantissas,
// stage 3 (fp_round_pack) normalises, rounds and packs into the output
// register. All stages advance together under a single global stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int XW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  // Denormals (exp == 0) are treated as zero here
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e != '1) return CLS_NORM;
    if (f == '0) return CLS_INF;
    return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic                 advance;

  logic                 s1_valid_d, s1_valid_q;
  logic                 s1_sign_d, s1_sign_q;
  fp_class_e            s1_cls_a_d, s1_cls_a_q, s1_cls_b_d, s1_cls_b_q;
  logic signed [XW-1:0] s1_exp_d, s1_exp_q;
  logic [MAN_W:0]       s1_man_a_d, s1_man_a_q, s1_man_b_d, s1_man_b_q;

  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_sign_d, s2_sign_q;
  fp_class_e            s2_cls_a_d, s2_cls_a_q, s2_cls_b_d, s2_cls_b_q;
  logic signed [XW-1:0] s2_exp_d, s2_exp_q;
  logic [PW-1:0]        s2_prod_d, s2_prod_q;

  logic                 out_valid_d, out_valid_q;
  logic [W-1:0]         result_d, result_q;
  logic [3:0]           flags_d, flags_q;

  logic [W-1:0]         rp_result;
  logic [3:0]           rp_flags;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (s2_sign_q),
    .cls_a  (s2_cls_a_q),
    .cls_b  (s2_cls_b_q),
    .exp_in (s2_exp_q),
    .prod   (s2_prod_q),
    .result (rp_result),
    .flags  (rp_flags)
  );

  // Global stall: the whole pipe moves only when the output slot can be freed
  always_comb begin
    advance     = out_ready || !out_valid_q;

    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_cls_a_d  = s1_cls_a_q;
    s1_cls_b_d  = s1_cls_b_q;
    s1_exp_d    = s1_exp_q;
    s1_man_a_d  = s1_man_a_q;
    s1_man_b_d  = s1_man_b_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_a_d  = s2_cls_a_q;
    s2_cls_b_d  = s2_cls_b_q;
    s2_exp_d    = s2_exp_q;
    s2_prod_d   = s2_prod_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = a[W-1] ^ b[W-1];
        s1_cls_a_d = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
        s1_cls_b_d = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
        s1_exp_d   = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]})
                     - $signed(XW'(BIAS));
        s1_man_a_d = {1'b1, a[MAN_W-1:0]};
        s1_man_b_d = {1'b1, b[MAN_W-1:0]};
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d  = s1_sign_q;
        s2_cls_a_d = s1_cls_a_q;
        s2_cls_b_d = s1_cls_b_q;
        s2_exp_d   = s1_exp_q;
        s2_prod_d  = PW'(s1_man_a_q) * PW'(s1_man_b_q);
      end

      // Result and flags are only replaced by a real result, so they stay put while idle
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        result_d = rp_result;
        flags_d  = rp_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_a_q  <= CLS_ZERO;
      s1_cls_b_q  <= CLS_ZERO;
      s1_exp_q    <= '0;
      s1_man_a_q  <= '0;
      s1_man_b_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_a_q  <= CLS_ZERO;
      s2_cls_b_q  <= CLS_ZERO;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_a_q  <= s1_man_a_d;
      s1_man_b_q  <= s1_man_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_a_q  <= s2_cls_a_d;
      s2_cls_b_q  <= s2_cls_b_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: self-checking bench for fp_mul_pipe.
// Single-precision instance u_dut is exercised with directed and random
// traffic against a reference model built on double-precision arithmetic;
// a half-precision instance u_half covers the parameterised widths.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_a;
  logic [15:0] h_b;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [15:0] h_result;
  logic [3:0]  h_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [35:0] exp_q[$];
  logic [31:0] got_res_q[$];
  logic [3:0]  got_flg_q[$];
  int          got_cyc_q[$];
  int          acc_cyc_q[$];
  logic        last_acc;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .a         (h_a),
    .b         (h_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .result    (h_result),
    .flags     (h_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Operand magnitude as a real, via the double-precision bit layout
  function automatic real op_to_real(input logic [31:0] x);
    logic [63:0] d;
    d = {1'b0, {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: {flags, result}. The exact double product is rounded to
  // single precision with round-to-nearest-even.
  function automatic logic [35:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, zx, zy, ix, iy, nx_, ny, snx, sny, up, nxf;
    logic [63:0] pb;
    logic [22:0] keep;
    logic [28:0] rem;
    logic [23:0] k24;
    real         p;
    int          e;
    s   = x[31] ^ y[31];
    zx  = (x[30:23] == 8'h00);
    zy  = (y[30:23] == 8'h00);
    ix  = (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
    iy  = (y[30:23] == 8'hff) && (y[22:0] == 23'd0);
    nx_ = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    ny  = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
    snx = nx_ && !x[22];
    sny = ny && !y[22];
    if (nx_ || ny || (zx && iy) || (ix && zy))
      return {(snx || sny || (zx && iy) || (ix && zy)), 3'b000, 32'h7fc00000};
    if (ix || iy) return {4'b0000, s, 8'hff, 23'd0};
    if (zx || zy) return {4'b0000, s, 31'd0};
    p    = op_to_real(x) * op_to_real(y);
    pb   = $realtobits(p);
    e    = int'(pb[62:52]) - 1023 + 127;
    keep = pb[51:29];
    rem  = pb[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    k24  = {1'b0, keep} + 24'(up);
    if (k24[23]) e = e + 1;
    nxf  = (rem != 29'd0);
    if (e >= 255) return {4'b0101, s, 8'hff, 23'd0};
    if (e <= 0)   return {4'b0011, s, 31'd0};
    return {3'b000, nxf, s, e[7:0], k24[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    int          sel;
    x   = $urandom;
    sel = $urandom_range(0, 19);
    case (sel)
      0: x[30:23] = 8'h00;
      1: begin x[30:23] = 8'hff; x[22:0] = 23'd0; end
      2: begin x[30:23] = 8'hff; x[0] = 1'b1; end
      3: x[30:23] = 8'($urandom_range(1, 254));
      4: x[30:23] = 8'($urandom_range(190, 254));
      5: x[30:23] = 8'($urandom_range(1, 64));
      default: x[30:23] = 8'($urandom_range(67, 187));
    endcase
    return x;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    got_res_q.delete();
    got_flg_q.delete();
    got_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  // One clock cycle starting at a falling edge: drive, observe handshakes, advance
  task automatic cycle_step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      got_res_q.push_back(result);
      got_flg_q.push_back(flags);
      got_cyc_q.push_back(cycle);
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(model_mul(a, b));
      acc_cyc_q.push_back(cycle);
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && got_res_q.size() < acc_cyc_q.size(); i++)
      cycle_step(1'b0, 32'd0, 32'd0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    n_checks++; if (flags !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_a [3] = '{32'h41a00000, 32'h41c80000, 32'h42800000};
    logic [31:0] op_b [3] = '{32'h41f00000, 32'h42340000, 32'h442f0000};
    logic [31:0] want [3] = '{32'h44160000, 32'h448ca000, 32'h472f0000};
    clear_queues();
    for (int i = 0; i < 3; i++) cycle_step(1'b1, op_a[i], op_b[i], 1'b1);
    drain(10);
    n_checks++; if (got_res_q.size() != 3) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 3", got_res_q.size()); end
    for (int i = 0; i < 3 && i < got_res_q.size(); i++) begin
      n_checks++; if (got_res_q[i] !== want[i]) begin n_fail++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, got_res_q[i], want[i]); end
      n_checks++; if (got_flg_q[i] !== 4'd0) begin n_fail++; $display("[TB] FAIL b2b_flags[%0d]: got %b expected 0000", i, got_flg_q[i]); end
      n_checks++; if (got_cyc_q[i] - acc_cyc_q[i] != 3) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 3", i, got_cyc_q[i] - acc_cyc_q[i]); end
      n_checks++; if (got_cyc_q[i] != got_cyc_q[0] + i) begin n_fail++; $display("[TB] FAIL b2b_consecutive[%0d]: got cycle %0d expected %0d", i, got_cyc_q[i], got_cyc_q[0] + i); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] op_a [2] = '{32'h3f800001, 32'h3f800001};
    logic [31:0] op_b [2] = '{32'h3f800001, 32'h3f800000};
    logic [31:0] want [2] = '{32'h3f800002, 32'h3f800001};
    logic [3:0]  wflg [2] = '{4'b0001, 4'b0000};
    clear_queues();
    for (int i = 0; i < 2; i++) cycle_step(1'b1, op_a[i], op_b[i], 1'b1);
    drain(10);
    n_checks++; if (got_res_q.size() != 2) begin n_fail++; $display("[TB] FAIL round_count: got %0d expected 2", got_res_q.size()); end
    for (int i = 0; i < 2 && i < got_res_q.size(); i++) begin
      n_checks++; if (got_res_q[i] !== want[i]) begin n_fail++; $display("[TB] FAIL round_result[%0d]: got %h expected %h", i, got_res_q[i], want[i]); end
      n_checks++; if (got_flg_q[i] !== wflg[i]) begin n_fail++; $display("[TB] FAIL round_flags[%0d]: got %b expected %b", i, got_flg_q[i], wflg[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] op_a [7] = '{32'h00000000, 32'hff800000, 32'h7f000000, 32'h00800000,
                              32'h7f800001, 32'h7fc00000, 32'h80000000};
    logic [31:0] op_b [7] = '{32'h7f800000, 32'h40000000, 32'h7f000000, 32'h00800000,
                              32'h3f800000, 32'h40000000, 32'h40000000};
    logic [31:0] want [7] = '{32'h7fc00000, 32'hff800000, 32'h7f800000, 32'h00000000,
                              32'h7fc00000, 32'h7fc00000, 32'h80000000};
    logic [3:0]  wflg [7] = '{4'b1000, 4'b0000, 4'b0101, 4'b0011, 4'b1000, 4'b0000, 4'b0000};
    clear_queues();
    for (int i = 0; i < 7; i++) cycle_step(1'b1, op_a[i], op_b[i], 1'b1);
    drain(12);
    n_checks++; if (got_res_q.size() != 7) begin n_fail++; $display("[TB] FAIL special_count: got %0d expected 7", got_res_q.size()); end
    for (int i = 0; i < 7 && i < got_res_q.size(); i++) begin
      n_checks++; if (got_res_q[i] !== want[i]) begin n_fail++; $display("[TB] FAIL special_result[%0d]: got %h expected %h", i, got_res_q[i], want[i]); end
      n_checks++; if (got_flg_q[i] !== wflg[i]) begin n_fail++; $display("[TB] FAIL special_flags[%0d]: got %b expected %b", i, got_flg_q[i], wflg[i]); end
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int i = 0; i < 400; i++)
      cycle_step($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 3) != 0);
    drain(40);
    n_checks++; if (got_res_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL random_count: got %0d expected %0d", got_res_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_res_q.size(); i++) begin
      n_checks++; if (got_res_q[i] !== exp_q[i][31:0]) begin n_fail++; $display("[TB] FAIL random_result[%0d]: got %h expected %h", i, got_res_q[i], exp_q[i][31:0]); end
      n_checks++; if (got_flg_q[i] !== exp_q[i][35:32]) begin n_fail++; $display("[TB] FAIL random_flags[%0d]: got %b expected %b", i, got_flg_q[i], exp_q[i][35:32]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] op_a [5];
    logic [31:0] op_b [5];
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    int          idx;
    clear_queues();
    for (int i = 0; i < 5; i++) begin op_a[i] = rand_op(); op_b[i] = rand_op(); end
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_step(1'b1, op_a[idx], op_b[idx], 1'b0);
      if (last_acc) idx++;
    end
    n_checks++; if (idx != 3) begin n_fail++; $display("[TB] FAIL bp_accepts: got %0d expected 3", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid); end
    held_res = result;
    held_flg = flags;
    for (int i = 0; i < 4; i++) begin
      cycle_step(1'b1, op_a[idx], op_b[idx], 1'b0);
      if (last_acc) idx++;
      n_checks++; if (result !== held_res || flags !== held_flg || out_valid !== 1'b1)
        begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got %h/%b/%b expected %h/%b/1", i, result, flags, out_valid, held_res, held_flg); end
    end
    for (int i = 0; i < 20 && idx < 5; i++) begin
      cycle_step(1'b1, op_a[idx], op_b[idx], 1'b1);
      if (last_acc) idx++;
    end
    drain(10);
    n_checks++; if (got_res_q.size() != 5 || exp_q.size() != 5)
      begin n_fail++; $display("[TB] FAIL bp_drain_count: got %0d/%0d expected 5/5", got_res_q.size(), exp_q.size()); end
    if (got_res_q.size() > 0) begin
      n_checks++; if (got_res_q[0] !== held_res) begin n_fail++; $display("[TB] FAIL bp_head: got %h expected %h", got_res_q[0], held_res); end
    end
    for (int i = 0; i < exp_q.size() && i < got_res_q.size(); i++) begin
      n_checks++; if (got_res_q[i] !== exp_q[i][31:0] || got_flg_q[i] !== exp_q[i][35:32])
        begin n_fail++; $display("[TB] FAIL bp_order[%0d]: got %h/%b expected %h/%b", i, got_res_q[i], got_flg_q[i], exp_q[i][31:0], exp_q[i][35:32]); end
    end
  endtask

  task automatic test_reset_midflight();
    clear_queues();
    cycle_step(1'b1, 32'h40400000, 32'h40400000, 1'b0);
    cycle_step(1'b1, 32'h40a00000, 32'h40a00000, 1'b0);
    cycle_step(1'b0, 32'd0, 32'd0, 1'b0);
    cycle_step(1'b0, 32'd0, 32'd0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || result !== 32'h41100000)
      begin n_fail++; $display("[TB] FAIL midrst_pre: got %b/%h expected 1/41100000", out_valid, result); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_result: got %h expected 00000000", result); end
    n_checks++; if (flags !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b expected 0000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    clear_queues();
    for (int i = 0; i < 8; i++) cycle_step(1'b0, 32'd0, 32'd0, 1'b1);
    n_checks++; if (got_res_q.size() != 0) begin n_fail++; $display("[TB] FAIL midrst_ghost: got %0d outputs expected 0", got_res_q.size()); end
  endtask

  task automatic test_half_precision();
    int lat;
    h_in_valid  = 1'b1;
    h_a         = 16'h4000;
    h_b         = 16'h4200;
    h_out_ready = 1'b1;
    #1;
    n_checks++; if (h_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL half_in_ready: got %b expected 1", h_in_ready); end
    @(posedge clk);
    @(negedge clk);
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("[TB] FAIL half_latency: got %0d expected 3", lat); end
    n_checks++; if (h_result !== 16'h4600) begin n_fail++; $display("[TB] FAIL half_result: got %h expected 4600", h_result); end
    n_checks++; if (h_flags !== 4'd0) begin n_fail++; $display("[TB] FAIL half_flags: got %b expected 0000", h_flags); end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = 32'd0;
    b           = 32'd0;
    out_ready   = 1'b0;
    h_in_valid  = 1'b0;
    h_a         = 16'd0;
    h_b         = 16'd0;
    h_out_ready = 1'b1;
    last_acc    = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] directed back-to-back");
    test_back_to_back();
    test_rounding();
    test_specials();
    $display("[TB] random traffic");
    test_random();
    test_back_pressure();
    test_reset_midflight();
    test_half_precision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
